nios_sampler_pio_key_inputs: RTL



---
 rtl/nios_sampler_pio_key_inputs.sv | 100 ++++++++++
 1 files changed

// File: rtl/nios_sampler_pio_key_inputs.sv
// Avalon-MM input PIO: synchronizes and debounces external keys, latches edges into a
// sticky capture register and raises a maskable level interrupt.
module nios_sampler_pio_key_inputs #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise, fall, capture, clr;
    logic             wr;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_comb begin
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        if (EDGE_TYPE == 0) begin
            capture = rise;
        end else if (EDGE_TYPE == 1) begin
            capture = fall;
        end else begin
            capture = rise | fall;
        end
        clr    = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
        // A newly accepted edge beats a same-cycle clear.
        edge_d = (edge_q & ~clr) | capture;
        mask_d = (wr && address == 3'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= in_port;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            3'd0:    readdata[WIDTH-1:0] = stable_q;
            3'd2:    readdata[WIDTH-1:0] = mask_q;
            3'd3:    readdata[WIDTH-1:0] = edge_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

endmodule
